canonical_code_assigner: RTL and testbench

- Downstream stage of the code-size sorter in the canonical Huffman encoder.
- Walks the ascending-sorted (code size, symbol ID) list one entry per cycle and assigns canonical codewords.
- Writes each code and its length into tables indexed by symbol ID. The bitstream packer consumes these tables.
- Flags invalid length sets (Kraft overflow, unsorted input, over-long codes).

---
 rtl/canonical_code_assigner.sv | 168 ++++++++++++++++
 tb/tb_canonical_code_assigner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/canonical_code_assigner.sv
// canonical_code_assigner: walks the ascending (code size, symbol ID) list
// produced by the code-size sorter, one entry per cycle, and builds the
// canonical codeword and length tables indexed by symbol ID. Invalid length
// sets (Kraft overflow, unsorted input, over-long codes) raise a sticky error.
// Optional build macro: CANON_CODE_BITREV_EN bit-reverses each published code
// within its own length for an LSB-first packer.
module canonical_code_assigner #(
  parameter int SYMBOLS         = 16,
  parameter int CODE_SIZE_WIDTH = 5,
  parameter int SYMBOL_ID_WIDTH = 4,
  parameter int MAX_CODE_LEN    = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   sorted_code_size_flat,
  input  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   sorted_symbol_id_flat,
  output logic [SYMBOLS*MAX_CODE_LEN-1:0]      code_flat,
  output logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   code_len_flat,
  output logic [SYMBOL_ID_WIDTH:0]             used_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam logic [SYMBOL_ID_WIDTH-1:0] LAST_IDX  = SYMBOL_ID_WIDTH'(SYMBOLS - 1);
  localparam logic [SYMBOL_ID_WIDTH-1:0] IDX_ONE   = SYMBOL_ID_WIDTH'(1);
  localparam logic [SYMBOL_ID_WIDTH:0]   COUNT_ONE = (SYMBOL_ID_WIDTH + 1)'(1);
  localparam logic [CODE_SIZE_WIDTH-1:0] MAX_LEN   = CODE_SIZE_WIDTH'(MAX_CODE_LEN);
  localparam logic [MAX_CODE_LEN:0]      CODE_ONE  = (MAX_CODE_LEN + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, ASSIGN, FIN} state_t;

  state_t                       state;
  logic [CODE_SIZE_WIDTH-1:0]   cap_size [SYMBOLS];
  logic [SYMBOL_ID_WIDTH-1:0]   cap_id   [SYMBOLS];
  logic [MAX_CODE_LEN-1:0]      tbl_code [SYMBOLS];
  logic [CODE_SIZE_WIDTH-1:0]   tbl_len  [SYMBOLS];
  logic [SYMBOL_ID_WIDTH-1:0]   idx;
  logic                         first;
  logic [CODE_SIZE_WIDTH-1:0]   prev;
  // One extra bit so a Kraft overflow at the maximum length is still visible.
  logic [MAX_CODE_LEN:0]        code;
  logic                         error_int;
  logic [SYMBOL_ID_WIDTH:0]     count;

  logic [CODE_SIZE_WIDTH-1:0]   cur_len;
  logic [SYMBOL_ID_WIDTH-1:0]   cur_id;
  logic [CODE_SIZE_WIDTH-1:0]   shift;
  logic [MAX_CODE_LEN:0]        code_next;
  logic                         entry_err;

  // Shape a stored code for the published table (optionally bit-reversed within L).
  function automatic logic [MAX_CODE_LEN-1:0] out_code(
    input logic [MAX_CODE_LEN-1:0]    c,
    input logic [CODE_SIZE_WIDTH-1:0] len
  );
`ifdef CANON_CODE_BITREV_EN
    logic [MAX_CODE_LEN-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_CODE_LEN; b++) begin
      if ((b < int'(len)) && (int'(len) - 1 - b < MAX_CODE_LEN))
        r[int'(len) - 1 - b] = c[b];
    end
    return r;
`else
    return (len == '0) ? '0 : c;
`endif
  endfunction

  // Next canonical code and validity checks for the entry at idx.
  always_comb begin
    cur_len   = cap_size[idx];
    cur_id    = cap_id[idx];
    shift     = cur_len - prev;
    code_next = '0;
    entry_err = 1'b0;
    if (!first)
      code_next = (code + CODE_ONE) << shift;
    if (cur_len != '0) begin
      if (cur_len > MAX_LEN)
        entry_err = 1'b1;
      if (!first && (cur_len < prev))
        entry_err = 1'b1;
      if ((code_next >> cur_len) != '0)
        entry_err = 1'b1;
    end
  end

  // Control FSM with table updates and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      first         <= 1'b1;
      prev          <= '0;
      code          <= '0;
      error_int     <= 1'b0;
      count         <= '0;
      code_flat     <= '0;
      code_len_flat <= '0;
      used_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      for (int s = 0; s < SYMBOLS; s++) begin
        cap_size[s] <= '0;
        cap_id[s]   <= '0;
        tbl_code[s] <= '0;
        tbl_len[s]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int s = 0; s < SYMBOLS; s++) begin
              cap_size[s] <= sorted_code_size_flat[s*CODE_SIZE_WIDTH +: CODE_SIZE_WIDTH];
              cap_id[s]   <= sorted_symbol_id_flat[s*SYMBOL_ID_WIDTH +: SYMBOL_ID_WIDTH];
              tbl_code[s] <= '0;
              tbl_len[s]  <= '0;
            end
            idx       <= '0;
            first     <= 1'b1;
            prev      <= '0;
            code      <= '0;
            error_int <= 1'b0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= ASSIGN;
        end
        ASSIGN: begin
          if (cur_len != '0) begin
            tbl_code[cur_id] <= code_next[MAX_CODE_LEN-1:0];
            tbl_len[cur_id]  <= cur_len;
            code             <= code_next;
            prev             <= cur_len;
            first            <= 1'b0;
            count            <= count + COUNT_ONE;
            if (entry_err)
              error_int <= 1'b1;
          end
          if (idx == LAST_IDX)
            state <= FIN;
          else
            idx <= idx + IDX_ONE;
        end
        FIN: begin
          for (int s = 0; s < SYMBOLS; s++) begin
            code_flat[s*MAX_CODE_LEN +: MAX_CODE_LEN]         <= out_code(tbl_code[s], tbl_len[s]);
            code_len_flat[s*CODE_SIZE_WIDTH +: CODE_SIZE_WIDTH] <= tbl_len[s];
          end
          used_count <= count;
          error      <= error_int;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canonical_code_assigner.sv
// Bench for canonical_code_assigner: table of input vectors with hand-derived
// expected tables, a scoreboard queue, plus mid-run start and reset sequences.
module tb_canonical_code_assigner;
  localparam int S  = 16;
  localparam int CW = 5;
  localparam int IW = 4;
  localparam int ML = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [S*CW-1:0]   sizes;
  logic [S*IW-1:0]   ids;
  logic [S*ML-1:0]   code_flat;
  logic [S*CW-1:0]   code_len_flat;
  logic [IW:0]       used_count;
  logic              busy;
  logic              done;
  logic              error;

  canonical_code_assigner dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .sorted_code_size_flat (sizes),
    .sorted_symbol_id_flat (ids),
    .code_flat             (code_flat),
    .code_len_flat         (code_len_flat),
    .used_count            (used_count),
    .busy                  (busy),
    .done                  (done),
    .error                 (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [S*CW-1:0] sz;
    logic [S*IW-1:0] id;
    logic [S*ML-1:0] ecode;
    logic [S*CW-1:0] elen;
    logic [IW:0]     eused;
    logic            eerr;
    bit              chk_tbl;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [IW:0] last_used = '0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [S*CW-1:0] put5(input logic [S*CW-1:0] f, input int i, input int v);
    f[i*CW +: CW] = CW'(v);
    return f;
  endfunction

  function automatic logic [S*IW-1:0] put4(input logic [S*IW-1:0] f, input int i, input int v);
    f[i*IW +: IW] = IW'(v);
    return f;
  endfunction

  function automatic logic [S*ML-1:0] put15(input logic [S*ML-1:0] f, input int i, input int v);
    f[i*ML +: ML] = ML'(v);
    return f;
  endfunction

  // Expected code: natural canonical value or its bit-reversed form.
  function automatic int ex(input int nat, input int br);
`ifdef CANON_CODE_BITREV_EN
    return br;
`else
    return nat;
`endif
  endfunction

  function automatic vec_t blank(input string nm);
    vec_t v;
    v.name = nm; v.sz = '0; v.id = '0; v.ecode = '0; v.elen = '0;
    v.eused = '0; v.eerr = 1'b0; v.chk_tbl = 1'b1;
    return v;
  endfunction

  // Place a nonzero entry: sorted slot e gets length L for symbol sym.
  function automatic vec_t ent(input vec_t v, input int e, input int L, input int sym, input int c);
    v.sz    = put5(v.sz, e, L);
    v.id    = put4(v.id, e, sym);
    v.ecode = put15(v.ecode, sym, c);
    v.elen  = put5(v.elen, sym, L);
    return v;
  endfunction

  task automatic run(input vec_t v, input bit mid_start);
    vec_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    sizes = v.sz; ids = v.id; start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    check({v.name, "/busy_after_start"}, 256'(busy), 256'(1));
    for (int k = 1; k <= 40; k++) begin
      if (mid_start && k == 5) begin start = 1'b1; sizes = '1; ids = '0; end
      if (k == 6) start = 1'b0;
      @(negedge clk);
      if (k == 9) check({v.name, "/hold_used"}, 256'(used_count), 256'(last_used));
      if (k == 9) check({v.name, "/busy_mid"}, 256'(busy), 256'(1));
      if (done) begin
        got = 1'b1;
        e = sb.pop_front();
        check({e.name, "/latency"}, 256'(k), 256'(18));
        check({e.name, "/busy_at_done"}, 256'(busy), 256'(0));
        check({e.name, "/used_count"}, 256'(used_count), 256'(e.eused));
        check({e.name, "/error"}, 256'(error), 256'(e.eerr));
        if (e.chk_tbl) begin
          check({e.name, "/code_flat"}, 256'(code_flat), 256'(e.ecode));
          check({e.name, "/code_len_flat"}, 256'(code_len_flat), 256'(e.elen));
        end
        last_used = e.eused;
        break;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s/timeout: got no done expected done within 40 cycles", v.name);
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check({v.name, "/done_single"}, 256'(done), 256'(0));
    end
  endtask

  initial begin
    vec_t v;
    bit   seen;

    // Nominal: sizes 11x0 then 2,2,2,3,3 for symbols 5,9,1,14,3.
    v = blank("nominal");
    v = ent(v, 11, 2, 5,  ex(0, 0));
    v = ent(v, 12, 2, 9,  ex(1, 2));
    v = ent(v, 13, 2, 1,  ex(2, 1));
    v = ent(v, 14, 3, 14, ex(6, 3));
    v = ent(v, 15, 3, 3,  ex(7, 7));
    v.eused = 5;
    vecs[0] = v;

    v = blank("kraft");
    v = ent(v, 13, 1, 2, 0);
    v = ent(v, 14, 1, 4, 0);
    v = ent(v, 15, 1, 6, 0);
    v.eused = 3; v.eerr = 1'b1; v.chk_tbl = 1'b0;
    vecs[1] = v;

    v = blank("unsorted");
    v = ent(v, 14, 3, 1, 0);
    v = ent(v, 15, 2, 2, 0);
    v.eused = 2; v.eerr = 1'b1; v.chk_tbl = 1'b0;
    vecs[2] = v;

    v = blank("overlong");
    v = ent(v, 15, 16, 0, 0);
    v.eused = 1; v.eerr = 1'b1; v.chk_tbl = 1'b0;
    vecs[3] = v;

    v = blank("all_zero");
    vecs[4] = v;

    v = blank("single");
    v = ent(v, 15, 1, 7, 0);
    v.eused = 1;
    vecs[5] = v;

    // Duplicate ID 3: the second entry (code 1) overwrites the first.
    v = blank("duplicate");
    v.sz = put5(v.sz, 14, 1); v.id = put4(v.id, 14, 3);
    v = ent(v, 15, 1, 3, ex(1, 1));
    v.eused = 2;
    vecs[6] = v;

    // Complete tree 1,2,...,15,15: length k gets 2^k-2 (ones then a zero).
    v = blank("full_tree");
    for (int i = 0; i < 15; i++)
      v = ent(v, i, i + 1, i, ex((1 << (i + 1)) - 2, (1 << i) - 1));
    v = ent(v, 15, 15, 15, 32767);
    v.eused = 16;
    vecs[7] = v;

    reset = 1'b1; start = 1'b0; sizes = '0; ids = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset/code_flat", 256'(code_flat), 256'(0));
    check("reset/code_len_flat", 256'(code_len_flat), 256'(0));
    check("reset/used_count", 256'(used_count), 256'(0));
    check("reset/busy", 256'(busy), 256'(0));
    check("reset/done", 256'(done), 256'(0));
    check("reset/error", 256'(error), 256'(0));

    for (int i = 0; i < 8; i++)
      run(vecs[i], 1'b0);

    // Extra start pulse mid-run must be ignored.
    vecs[0].name = "nominal_midstart";
    run(vecs[0], 1'b1);

    // Reset while ASSIGN processes idx 5 (edge E7).
    @(negedge clk);
    sizes = vecs[5].sz; ids = vecs[5].id; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset/code_flat", 256'(code_flat), 256'(0));
    check("midreset/code_len_flat", 256'(code_len_flat), 256'(0));
    check("midreset/used_count", 256'(used_count), 256'(0));
    check("midreset/busy", 256'(busy), 256'(0));
    check("midreset/error", 256'(error), 256'(0));
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midreset/no_done", 256'(seen), 256'(0));
    last_used = '0;

    vecs[0].name = "nominal_after_reset";
    run(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
